// File: rtl/vsc8541_pkg.sv
// Shared definitions for the VSC8541 status poller: PHY register addresses,
// status bit positions, speed encoding and the poller state encoding.
package vsc8541_pkg;

  localparam logic [4:0] REG_BMSR       = 5'd1;
  localparam logic [4:0] REG_AUX_STATUS = 5'd28;

  localparam int BMSR_LINK_BIT  = 2;
  localparam int BMSR_ANEG_BIT  = 5;
  localparam int AUX_FDX_BIT    = 5;
  localparam int AUX_SPEED_LSB  = 3;
  localparam int AUX_SPEED_MSB  = 4;

  // Code 11 is reserved by the PHY and is passed through untouched
  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10,
    SPEED_RSVD = 2'b11
  } speed_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ_BMSR  = 3'd1,
    ST_WAIT_BMSR = 3'd2,
    ST_REQ_AUX   = 3'd3,
    ST_WAIT_AUX  = 3'd4,
    ST_UPDATE    = 3'd5
  } poll_state_e;

endpackage

// File: rtl/vsc8541_poll_timer.sv
// Loadable down-counter that paces the poller. Counts toward zero unless
// held, saturates at zero and reports it through a zero flag. The reset
// value is a parameter so the first poll is spaced like every later one.
module vsc8541_poll_timer #(
  parameter int               WIDTH       = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_hold,
  output logic             o_zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down while not held, stopping at zero
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= RESET_VALUE;
    end else if (i_load) begin
      count <= i_load_value;
    end else if (!i_hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/vsc8541_status_poller.sv
// Periodic VSC8541 link-status poller. Reads BMSR then the auxiliary status
// register through the downstream MDIO register reader and publishes link,
// auto-negotiation, speed and duplex as registered outputs.
// Optional feature macro: VSC8541_POLL_TIMEOUT_EN adds a per-read watchdog
// that abandons a stuck read and raises a sticky o_error.
module vsc8541_status_poller
  import vsc8541_pkg::*;
#(
  parameter int POLL_CYCLES    = 1_000_000,
  parameter int MDC_DIVISOR    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  output logic [4:0]  o_register,
  output logic        o_read_en,
  input  logic [14:0] i_data,
  input  logic        i_dv,
  output logic        o_link_up,
  output logic        o_aneg_done,
  output logic [1:0]  o_speed,
  output logic        o_full_duplex,
  output logic        o_status_valid,
  output logic        o_link_change,
  output logic        o_error
);

  localparam int                 TIMER_W      = $clog2(POLL_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);
  localparam int                 HOLD_W       = $clog2(MDC_DIVISOR + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(MDC_DIVISOR);

  poll_state_e       state;
  poll_state_e       next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold_cnt;
  logic              next_read_en;
  logic [4:0]        next_register;
  logic              timer_load;
  logic              timer_zero;
  logic              in_req;
  logic              in_wait;
  logic              timeout;
  logic [14:0]       bmsr_q;
  logic [14:0]       aux_q;
  speed_e            aux_speed;
  logic              unused_bits;

  assign in_req  = (state == ST_REQ_BMSR) || (state == ST_REQ_AUX);
  assign in_wait = (state == ST_WAIT_BMSR) || (state == ST_WAIT_AUX);

  vsc8541_poll_timer #(
    .WIDTH       (TIMER_W),
    .RESET_VALUE (TIMER_RELOAD)
  ) u_timer (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_load       (timer_load),
    .i_load_value (TIMER_RELOAD),
    .i_hold       (state != ST_IDLE),
    .o_zero       (timer_zero)
  );

`ifdef VSC8541_POLL_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              error_q;

  // An i_dv on the final watchdog cycle still wins over the timeout
  assign timeout = in_wait && !i_dv && (wait_cnt == WAIT_LAST);

  // Count cycles spent waiting for the reader; cleared whenever not waiting
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign o_error = error_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign o_error        = 1'b0;
`endif

  // Next-state, request-hold and register-address decode
  always_comb begin
    next_state    = state;
    timer_load    = 1'b0;
    next_read_en  = 1'b0;
    next_hold_cnt = '0;
    next_register = 5'd0;

    case (state)
      ST_IDLE: begin
        if (timer_zero && i_enable) next_state = ST_REQ_BMSR;
      end
      ST_REQ_BMSR: begin
        if (hold_cnt == HOLD_LAST) next_state = ST_WAIT_BMSR;
      end
      ST_WAIT_BMSR: begin
        if (i_dv) begin
          next_state = ST_REQ_AUX;
        end else if (timeout) begin
          next_state = ST_IDLE;
          timer_load = 1'b1;
        end
      end
      ST_REQ_AUX: begin
        if (hold_cnt == HOLD_LAST) next_state = ST_WAIT_AUX;
      end
      ST_WAIT_AUX: begin
        if (i_dv) begin
          next_state = ST_UPDATE;
        end else if (timeout) begin
          next_state = ST_IDLE;
          timer_load = 1'b1;
        end
      end
      ST_UPDATE: begin
        next_state = ST_IDLE;
        timer_load = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (in_req && (hold_cnt != HOLD_LAST)) begin
      next_read_en  = 1'b1;
      next_hold_cnt = hold_cnt + 1'b1;
    end

    case (next_state)
      ST_REQ_BMSR, ST_WAIT_BMSR: next_register = REG_BMSR;
      ST_REQ_AUX,  ST_WAIT_AUX:  next_register = REG_AUX_STATUS;
      default:                   next_register = 5'd0;
    endcase
  end

  // State register plus the registered request interface to the reader
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      o_read_en  <= 1'b0;
      o_register <= 5'd0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_hold_cnt;
      o_read_en  <= next_read_en;
      o_register <= next_register;
    end
  end

  // Capture reader data only while waiting for the matching read
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bmsr_q <= '0;
      aux_q  <= '0;
    end else if (i_dv && (state == ST_WAIT_BMSR)) begin
      bmsr_q <= i_data;
    end else if (i_dv && (state == ST_WAIT_AUX)) begin
      aux_q <= i_data;
    end
  end

  assign aux_speed = speed_e'(aux_q[AUX_SPEED_MSB:AUX_SPEED_LSB]);

  // Publish status only in UPDATE so a half-finished poll never leaks out
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_link_up      <= 1'b0;
      o_aneg_done    <= 1'b0;
      o_speed        <= 2'b00;
      o_full_duplex  <= 1'b0;
      o_status_valid <= 1'b0;
      o_link_change  <= 1'b0;
    end else if (state == ST_UPDATE) begin
      o_link_up      <= bmsr_q[BMSR_LINK_BIT];
      o_aneg_done    <= bmsr_q[BMSR_ANEG_BIT];
      o_speed        <= aux_speed;
      o_full_duplex  <= aux_q[AUX_FDX_BIT];
      o_status_valid <= 1'b1;
      o_link_change  <= bmsr_q[BMSR_LINK_BIT] ^ o_link_up;
    end else begin
      o_link_change  <= 1'b0;
    end
  end

  // Only a few bits of each PHY register matter to the MAC/LED logic
  assign unused_bits = ^{bmsr_q, aux_q};

endmodule

// File: tb/tb_vsc8541_status_poller.sv
// Self-checking bench for vsc8541_status_poller with POLL_CYCLES=16,
// MDC_DIVISOR=2. Acts as the MDIO register reader, queues expected status
// per poll and compares when the poller publishes it.
module tb_vsc8541_status_poller;

  localparam int POLL = 16;
  localparam int MDC  = 2;
  localparam int TMO  = 8;

  typedef struct {
    logic       link;
    logic       aneg;
    logic [1:0] speed;
    logic       fdx;
    logic       change;
  } status_t;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_enable = 1'b1;
  logic [4:0]  o_register;
  logic        o_read_en;
  logic [14:0] i_data = '0;
  logic        i_dv = 1'b0;
  logic        o_link_up;
  logic        o_aneg_done;
  logic [1:0]  o_speed;
  logic        o_full_duplex;
  logic        o_status_valid;
  logic        o_link_change;
  logic        o_error;

  int checks = 0;
  int errors = 0;

  logic       model_link  = 1'b0;
  logic       model_aneg  = 1'b0;
  logic [1:0] model_speed = 2'b00;
  logic       model_fdx   = 1'b0;
  logic       model_valid = 1'b0;
  logic       model_error = 1'b0;
  status_t    exp_q[$];

  vsc8541_status_poller #(
    .POLL_CYCLES    (POLL),
    .MDC_DIVISOR    (MDC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_enable       (i_enable),
    .o_register     (o_register),
    .o_read_en      (o_read_en),
    .i_data         (i_data),
    .i_dv           (i_dv),
    .o_link_up      (o_link_up),
    .o_aneg_done    (o_aneg_done),
    .o_speed        (o_speed),
    .o_full_duplex  (o_full_duplex),
    .o_status_valid (o_status_valid),
    .o_link_change  (o_link_change),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    i_reset_n = 1'b0;
    i_dv      = 1'b0;
    i_data    = '0;
    repeat (2) @(negedge clk);
    i_reset_n   = 1'b1;
    model_link  = 1'b0;
    model_aneg  = 1'b0;
    model_speed = 2'b00;
    model_fdx   = 1'b0;
    model_valid = 1'b0;
    model_error = 1'b0;
  endtask

  // Reader model: wait for a request, check it, then answer after latency
  task automatic serve_read(input logic [4:0] exp_reg, input logic [14:0] data,
                            input int latency, input string name);
    int waited = 0;
    int high = 0;
    while (o_read_en !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (o_read_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_req_seen: got read_en=%b expected 1 within 200 cycles", name, o_read_en);
      return;
    end
    checks++;
    if (o_register !== exp_reg) begin
      errors++;
      $display("[TB] FAIL %s_req_addr: got %0d expected %0d", name, o_register, exp_reg);
    end
    while (o_read_en === 1'b1 && high < 20) begin
      high++;
      @(negedge clk);
    end
    checks++;
    if (high != MDC) begin
      errors++;
      $display("[TB] FAIL %s_req_len: got %0d expected %0d", name, high, MDC);
    end
    repeat (latency) @(negedge clk);
    checks++;
    if (o_register !== exp_reg || o_read_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_wait_hold: got reg=%0d re=%b expected reg=%0d re=0", name, o_register, o_read_en, exp_reg);
    end
    i_dv   = 1'b1;
    i_data = data;
    @(negedge clk);
    i_dv   = 1'b0;
    i_data = '0;
  endtask

  task automatic do_poll(input logic [14:0] bmsr, input logic [14:0] aux, input string name);
    status_t e;
    serve_read(5'd1, bmsr, 3, {name, "_bmsr"});
    serve_read(5'd28, aux, 2, {name, "_aux"});
    e.link   = bmsr[2];
    e.aneg   = bmsr[5];
    e.speed  = aux[4:3];
    e.fdx    = aux[5];
    e.change = (bmsr[2] != model_link);
    exp_q.push_back(e);
    checks++;
    if ({o_link_up, o_status_valid} !== {model_link, model_valid}) begin
      errors++;
      $display("[TB] FAIL %s_early: got %b expected %b", name, {o_link_up, o_status_valid}, {model_link, model_valid});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({o_link_up, o_aneg_done, o_speed, o_full_duplex, o_status_valid} !==
        {e.link, e.aneg, e.speed, e.fdx, 1'b1}) begin
      errors++;
      $display("[TB] FAIL %s_status: got %b expected %b", name,
               {o_link_up, o_aneg_done, o_speed, o_full_duplex, o_status_valid},
               {e.link, e.aneg, e.speed, e.fdx, 1'b1});
    end
    checks++;
    if (o_link_change !== e.change) begin
      errors++;
      $display("[TB] FAIL %s_change: got %b expected %b", name, o_link_change, e.change);
    end
    model_link  = e.link;
    model_aneg  = e.aneg;
    model_speed = e.speed;
    model_fdx   = e.fdx;
    model_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (o_link_change !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_change_len: got %b expected 0", name, o_link_change);
    end
  endtask

  task automatic test_reset();
    logic exp_re;
    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_register, o_read_en, o_link_up, o_aneg_done, o_speed, o_full_duplex,
         o_status_valid, o_link_change, o_error} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {o_register, o_read_en, o_link_up, o_aneg_done, o_speed, o_full_duplex,
                o_status_valid, o_link_change, o_error});
    end
    i_reset_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp_re = (k == 17) || (k == 18);
      checks++;
      if (o_read_en !== exp_re) begin
        errors++;
        $display("[TB] FAIL reset_first_req_c%0d: got %b expected %b", k, o_read_en, exp_re);
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (o_register !== ((k == 16) ? 5'd1 : 5'd0)) begin
          errors++;
          $display("[TB] FAIL reset_reg_c%0d: got %0d expected %0d", k, o_register, (k == 16) ? 1 : 0);
        end
      end
    end
    apply_reset();
  endtask

  task automatic test_first_poll();
    do_poll(15'h0024, 15'h0030, "first_poll");
    checks++;
    if ({o_link_up, o_aneg_done, o_speed, o_full_duplex, o_status_valid} !== 6'b11_10_11) begin
      errors++;
      $display("[TB] FAIL first_poll_const: got %b expected 111011",
               {o_link_up, o_aneg_done, o_speed, o_full_duplex, o_status_valid});
    end
  endtask

  task automatic test_repeat_polls();
    do_poll(15'h0024, 15'h0010, "same_link");
    do_poll(15'h0000, 15'h0018, "link_down_rsvd_speed");
  endtask

  task automatic test_stray_dv();
    checks++;
    if (o_register !== 5'd0) begin
      errors++;
      $display("[TB] FAIL stray_idle_reg: got %0d expected 0", o_register);
    end
    for (int i = 0; i < 3; i++) begin
      i_dv   = 1'b1;
      i_data = 15'h7FFF;
      @(negedge clk);
      checks++;
      if ({o_link_up, o_aneg_done, o_speed, o_full_duplex, o_read_en} !==
          {model_link, model_aneg, model_speed, model_fdx, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stray_dv_%0d: got %b expected %b", i,
                 {o_link_up, o_aneg_done, o_speed, o_full_duplex, o_read_en},
                 {model_link, model_aneg, model_speed, model_fdx, 1'b0});
      end
    end
    i_dv   = 1'b0;
    i_data = '0;
    do_poll(15'h0024, 15'h0030, "after_stray");
  endtask

  task automatic test_enable_gate();
    int reqs = 0;
    i_enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_read_en === 1'b1) reqs++;
    end
    checks++;
    if (reqs != 0 || o_register !== 5'd0) begin
      errors++;
      $display("[TB] FAIL enable_low: got reqs=%0d reg=%0d expected 0 0", reqs, o_register);
    end
    i_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (o_register !== 5'd1) begin
      errors++;
      $display("[TB] FAIL enable_rise: got reg=%0d expected 1", o_register);
    end
    do_poll(15'h0020, 15'h0008, "after_enable");
  endtask

`ifdef VSC8541_POLL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    while (o_read_en !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (o_read_en === 1'b1 && n < 220) begin @(negedge clk); n++; end
    checks++;
    if (o_read_en !== 1'b0 || o_register !== 5'd1) begin
      errors++;
      $display("[TB] FAIL timeout_enter_wait: got re=%b reg=%0d expected 0 1", o_read_en, o_register);
    end
    for (int j = 1; j <= TMO; j++) begin
      @(negedge clk);
      checks++;
      if (o_error !== (j == TMO)) begin
        errors++;
        $display("[TB] FAIL timeout_err_c%0d: got %b expected %b", j, o_error, (j == TMO));
      end
    end
    model_error = 1'b1;
    checks++;
    if ({o_link_up, o_aneg_done, o_speed, o_full_duplex} !==
        {model_link, model_aneg, model_speed, model_fdx}) begin
      errors++;
      $display("[TB] FAIL timeout_status_held: got %b expected %b",
               {o_link_up, o_aneg_done, o_speed, o_full_duplex},
               {model_link, model_aneg, model_speed, model_fdx});
    end
    do_poll(15'h0024, 15'h0030, "after_timeout");
  endtask
`endif

  task automatic test_reset_mid_read();
    int n = 0;
    serve_read(5'd1, 15'h0004, 3, "midreset_bmsr");
    while (o_read_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (o_read_en === 1'b1 && n < 70) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (o_register !== 5'd28 || o_status_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_in_wait_aux: got reg=%0d valid=%b expected 28 1", o_register, o_status_valid);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_register, o_read_en, o_link_up, o_aneg_done, o_speed, o_full_duplex,
         o_status_valid, o_link_change, o_error} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %0h expected 0",
               {o_register, o_read_en, o_link_up, o_aneg_done, o_speed, o_full_duplex,
                o_status_valid, o_link_change, o_error});
    end
    @(negedge clk);
    i_reset_n   = 1'b1;
    model_link  = 1'b0;
    model_aneg  = 1'b0;
    model_speed = 2'b00;
    model_fdx   = 1'b0;
    model_valid = 1'b0;
    model_error = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (o_read_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_restart_c%0d: got %b expected 0", k, o_read_en);
      end
    end
    checks++;
    if (o_register !== 5'd1) begin
      errors++;
      $display("[TB] FAIL midreset_restart_reg: got %0d expected 1", o_register);
    end
    do_poll(15'h0024, 15'h0030, "after_midreset");
  endtask

  task automatic test_error_flag();
    checks++;
    if (o_error !== model_error) begin
      errors++;
      $display("[TB] FAIL error_flag: got %b expected %b", o_error, model_error);
    end
  endtask

  initial begin
    $display("[TB] starting vsc8541_status_poller bench");
    test_reset();
    test_first_poll();
    test_repeat_polls();
    test_stray_dv();
    test_enable_gate();
`ifdef VSC8541_POLL_TIMEOUT_EN
    test_timeout();
`endif
    test_error_flag();
    test_reset_mid_read();
    test_error_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
